// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the three-requester memory port arbiter.
// Requester indices double as the 2-bit select encoding of the 3:1 address/data mux.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int unsigned NUM_REQ = 3;

    localparam logic [1:0] REQ_FETCH = 2'd0;
    localparam logic [1:0] REQ_LDST  = 2'd1;
    localparam logic [1:0] REQ_DBG   = 2'd2;

    // Successor of a requester index in the rotation fetch -> ldst -> dbg -> fetch.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == REQ_DBG) ? REQ_FETCH : idx + 2'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the requesters/memory side and the arbiter.
// slave: the arbiter itself; master: whatever drives requests and memory completion.
interface mem_port_arbiter_if;
    import mem_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] done;
    logic [1:0]         sel;
    logic               mem_valid;
    logic               mem_ready;
    logic               timeout_err;

    modport slave (
        input  req,
        input  mem_ready,
        output gnt,
        output done,
        output sel,
        output mem_valid,
        output timeout_err
    );

    modport master (
        output req,
        output mem_ready,
        input  gnt,
        input  done,
        input  sel,
        input  mem_valid,
        input  timeout_err
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick3.sv
// Combinational round-robin pick among three requesters.
// Search starts at the requester after 'last' and wraps; outputs are zero when nobody requests.
module rr_pick3
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [1:0]         last_i,
    output logic [NUM_REQ-1:0] win_onehot_o,
    output logic [1:0]         win_idx_o
);

    logic [1:0] cand;
    logic       found;

    always_comb begin
        // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
        win_idx_o    = REQ_FETCH;
        win_onehot_o = '0;
        found        = 1'b0;
        cand         = rr_next(last_i);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_i[cand]) begin
                found     = 1'b1;
                win_idx_o = cand;
            end
            cand = rr_next(cand);
        end
        if (found) begin
            win_onehot_o = NUM_REQ'(1) << win_idx_o;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer for the shared memory port: grant held until mem_ready, then done pulse.
// Optional BUSY watchdog enabled by defining MEM_ARB_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic              clk,
    input logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [1:0]         sel_q, sel_d;
    logic               mem_valid_q, mem_valid_d;
    logic               timeout_err_q, timeout_err_d;
    logic [1:0]         last_q, last_d;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [1:0]         pick_idx;

    rr_pick3 u_pick (
        .req_i        (bus.req),
        .last_i       (last_q),
        .win_onehot_o (pick_onehot),
        .win_idx_o    (pick_idx)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt_q + CNT_W'(1);
`else
    // Parameter kept so both builds share one instantiation signature.
    localparam int unsigned timeout_cycles_unused = TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        done_d        = '0;
        sel_d         = sel_q;
        mem_valid_d   = mem_valid_q;
        timeout_err_d = 1'b0;
        last_d        = last_q;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    gnt_d       = pick_onehot;
                    sel_d       = pick_idx;
                    mem_valid_d = 1'b1;
                    state_d     = BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end

            BUSY: begin
                // sel_q carries the winner index for the whole transaction.
                if (bus.mem_ready) begin
                    gnt_d       = '0;
                    mem_valid_d = 1'b0;
                    done_d      = gnt_q;
                    last_d      = sel_q;
                    state_d     = IDLE;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                    gnt_d         = '0;
                    mem_valid_d   = 1'b0;
                    done_d        = gnt_q;
                    last_d        = sel_q;
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
`endif
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            done_q        <= '0;
            sel_q         <= REQ_FETCH;
            mem_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            last_q        <= REQ_DBG;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            done_q        <= done_d;
            sel_q         <= sel_d;
            mem_valid_q   <= mem_valid_d;
            timeout_err_q <= timeout_err_d;
            last_q        <= last_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign bus.gnt         = gnt_q;
    assign bus.done        = done_q;
    assign bus.sel         = sel_q;
    assign bus.mem_valid   = mem_valid_q;
    assign bus.timeout_err = timeout_err_q;

endmodule
